// File: rtl/risc_cpu.sv
// risc_cpu: multi-cycle 8-bit accumulator CPU, 4-bit address space.
// Each instruction runs FETCH -> DECODE -> EXECUTE (HLT parks in HALT).
// Bus outputs are combinational decodes of state and IR, so a reset
// pulse drops `write` before any pending edge can commit a store.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   read       out  memory read strobe
//   write      out  memory write strobe (memory captures on rising edge)
//   memoryOut  in   8-bit combinational read data at `address`
//   memoryIn   out  8-bit write data, always the accumulator
//   address    out  4-bit memory address
module risc_cpu (
    input  logic       clk,
    input  logic       clr,
    output logic       read,
    output logic       write,
    input  logic [7:0] memoryOut,
    output logic [7:0] memoryIn,
    output logic [3:0] address
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_HLT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2,
                           OP_AND = 4'h3, OP_OR  = 4'h4, OP_STA = 4'h5,
                           OP_XOR = 4'h6, OP_LDA = 4'h7, OP_JMP = 4'h8,
                           OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_NOT = 4'hB,
                           OP_INC = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] ac_q, ac_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic [3:0] op;
    logic [8:0] alu_add, alu_sub, alu_inc;
    logic       ac_wr;

    assign op      = ir_q[7:4];
    // 9-bit results: bit 8 is carry for add/inc and borrow for sub
    assign alu_add = {1'b0, ac_q} + {1'b0, memoryOut};
    assign alu_sub = {1'b0, ac_q} - {1'b0, memoryOut};
    assign alu_inc = {1'b0, ac_q} + 9'd1;

    assign memoryIn = ac_q;

    // Bus decode
    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        address = pc_q;
        case (state_q)
            S_FETCH: begin
                address = pc_q;
                read    = 1'b1;
            end
            S_DECODE: address = ir_q[3:0];
            S_EXEC: begin
                address = ir_q[3:0];
                read    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                          (op == OP_OR)  || (op == OP_XOR) || (op == OP_LDA);
                write   = (op == OP_STA);
            end
            default: ;
        endcase
    end

    // Next-state / datapath
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        c_d     = c_q;
        z_d     = z_q;
        ac_wr   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = memoryOut;
                pc_d    = pc_q + 4'd1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD: begin {c_d, ac_d} = alu_add; ac_wr = 1'b1; end
                    OP_SUB: begin {c_d, ac_d} = alu_sub; ac_wr = 1'b1; end
                    OP_AND: begin ac_d = ac_q & memoryOut; ac_wr = 1'b1; end
                    OP_OR:  begin ac_d = ac_q | memoryOut; ac_wr = 1'b1; end
                    OP_XOR: begin ac_d = ac_q ^ memoryOut; ac_wr = 1'b1; end
                    OP_LDA: begin ac_d = memoryOut;        ac_wr = 1'b1; end
                    OP_JMP: pc_d = ir_q[3:0];
                    OP_JZ:  if (z_q) pc_d = ir_q[3:0];
                    OP_JC:  if (c_q) pc_d = ir_q[3:0];
                    OP_NOT: begin ac_d = ~ac_q;            ac_wr = 1'b1; end
                    OP_INC: begin {c_d, ac_d} = alu_inc; ac_wr = 1'b1; end
                    OP_SHL: begin c_d = ac_q[7]; ac_d = {ac_q[6:0], 1'b0}; ac_wr = 1'b1; end
                    OP_SHR: begin c_d = ac_q[0]; ac_d = {1'b0, ac_q[7:1]}; ac_wr = 1'b1; end
                    default: ;  // STA is a pure bus cycle; NOP does nothing
                endcase
                if (ac_wr) z_d = (ac_d == 8'h00);
            end
            default: ;  // HALT holds until reset
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_FETCH;
            pc_q    <= 4'h0;
            ir_q    <= 8'h00;
            ac_q    <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_risc_cpu.sv
// Testbench for risc_cpu: behavioural 16x8 memory, table of short programs
// with hand-computed end states, plus directed cycle-level sequences.
module tb_risc_cpu;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        read, write;
    logic [7:0]  memoryOut, memoryIn;
    logic [3:0]  address;

    logic [15:0][7:0] mem;
    logic [15:0][7:0] img;
    logic             ld = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory: combinational read, synchronous write; `ld` loads a program image
    assign memoryOut = mem[address];
    always @(posedge clk) begin
        if (ld)         mem <= img;
        else if (write) mem[address] <= memoryIn;
    end

    risc_cpu dut (
        .clk       (clk),
        .clr       (clr),
        .read      (read),
        .write     (write),
        .memoryOut (memoryOut),
        .memoryIn  (memoryIn),
        .address   (address)
    );

    typedef struct {
        logic [15:0][7:0] img;
        logic [7:0]       ac;
        logic             z;
        logic             c;
        logic [3:0]       pc;
        logic [3:0]       ma;
        logic [7:0]       md;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Hold reset, load image on one edge, release reset at a negedge
    task automatic boot(input logic [15:0][7:0] image);
        @(negedge clk);
        clr = 1'b0;
        img = image;
        ld  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld  = 1'b0;
        clr = 1'b1;
    endtask

    initial begin
        vec_t t;
        int   wcnt;
        logic [15:0][7:0] p;

        // ---------------- vector table ----------------
        // 0: ADD with carry: LDA 6 (FF), ADD 7 (02) -> 01, C=1
        t = '{default: '0};
        t.img[0] = 8'h76; t.img[1] = 8'h17; t.img[6] = 8'hFF; t.img[7] = 8'h02;
        t.ac = 8'h01; t.z = 0; t.c = 1; t.pc = 4'd3; t.ma = 4'd6; t.md = 8'hFF;
        vecs[0] = t;
        // 1: SUB to zero: 05 - 05
        t = '{default: '0};
        t.img[0] = 8'h76; t.img[1] = 8'h26; t.img[6] = 8'h05;
        t.ac = 8'h00; t.z = 1; t.c = 0; t.pc = 4'd3; t.ma = 4'd6; t.md = 8'h05;
        vecs[1] = t;
        // 2: SUB with borrow: 05 - 06 = FF, C=1
        t = '{default: '0};
        t.img[0] = 8'h77; t.img[1] = 8'h26; t.img[6] = 8'h06; t.img[7] = 8'h05;
        t.ac = 8'hFF; t.z = 0; t.c = 1; t.pc = 4'd3; t.ma = 4'd7; t.md = 8'h05;
        vecs[2] = t;
        // 3: JZ taken skips STA 8 at address 4
        t = '{default: '0};
        t.img[0] = 8'h77; t.img[1] = 8'h95; t.img[2] = 8'hFF; t.img[3] = 8'hFF;
        t.img[4] = 8'h58; t.img[5] = 8'h00; t.img[7] = 8'h00; t.img[8] = 8'hAA;
        t.ac = 8'h00; t.z = 1; t.c = 0; t.pc = 4'd6; t.ma = 4'd8; t.md = 8'hAA;
        vecs[3] = t;
        // 4: same with nonzero load: JZ falls through, STA 8 writes 33
        t = vecs[3];
        t.img[7] = 8'h33;
        t.ac = 8'h33; t.z = 0; t.c = 0; t.pc = 4'd6; t.ma = 4'd8; t.md = 8'h33;
        vecs[4] = t;
        // 5: logic ops then STA E: F0&3C=30 |05=35 ^FF=CA ~=35
        t = '{default: '0};
        t.img[0] = 8'h7A; t.img[1] = 8'h3B; t.img[2] = 8'h4C; t.img[3] = 8'h6D;
        t.img[4] = 8'hB0; t.img[5] = 8'h5E;
        t.img[10] = 8'hF0; t.img[11] = 8'h3C; t.img[12] = 8'h05; t.img[13] = 8'hFF;
        t.ac = 8'h35; t.z = 0; t.c = 0; t.pc = 4'd7; t.ma = 4'd14; t.md = 8'h35;
        vecs[5] = t;
        // 6: INC wraps FF -> 00 with C=1, Z=1
        t = '{default: '0};
        t.img[0] = 8'h79; t.img[1] = 8'hC0; t.img[9] = 8'hFF;
        t.ac = 8'h00; t.z = 1; t.c = 1; t.pc = 4'd3; t.ma = 4'd9; t.md = 8'hFF;
        vecs[6] = t;
        // 7: SHL/SHR chain: 81 -> 02 (C1) -> 01 (C0) -> 00 (C1)
        t = '{default: '0};
        t.img[0] = 8'h79; t.img[1] = 8'hD0; t.img[2] = 8'hE0; t.img[3] = 8'hE0;
        t.img[9] = 8'h81;
        t.ac = 8'h00; t.z = 1; t.c = 1; t.pc = 4'd5; t.ma = 4'd9; t.md = 8'h81;
        vecs[7] = t;
        // 8: INC sets C, JC 5 taken, INC clears C
        t = '{default: '0};
        t.img[0] = 8'h79; t.img[1] = 8'hC0; t.img[2] = 8'hA5; t.img[5] = 8'hC0;
        t.img[9] = 8'hFF;
        t.ac = 8'h01; t.z = 0; t.c = 0; t.pc = 4'd7; t.ma = 4'd9; t.md = 8'hFF;
        vecs[8] = t;
        // 9: JMP 4 over HLTs, LDA F
        t = '{default: '0};
        t.img[0] = 8'h84; t.img[4] = 8'h7F; t.img[15] = 8'h5A;
        t.ac = 8'h5A; t.z = 0; t.c = 0; t.pc = 4'd6; t.ma = 4'd15; t.md = 8'h5A;
        vecs[9] = t;
        // 10: STA E then ADD E reads the stored value: 12 + 11 = 23
        t = '{default: '0};
        t.img[0] = 8'h7F; t.img[1] = 8'h5E; t.img[2] = 8'hC0; t.img[3] = 8'h1E;
        t.img[15] = 8'h11;
        t.ac = 8'h23; t.z = 0; t.c = 0; t.pc = 4'd5; t.ma = 4'd14; t.md = 8'h11;
        vecs[10] = t;

        // ---------------- reset state ----------------
        #1;
        chk("rst address", 32'(address), 32'h0);
        chk("rst read", 32'(read), 32'h1);
        chk("rst write", 32'(write), 32'h0);
        chk("rst memoryIn", 32'(memoryIn), 32'h0);

        // ---------------- load/store sequence ----------------
        p = '0;
        p[0] = 8'h77; p[1] = 8'h54; p[2] = 8'h54; p[3] = 8'h00;
        p[6] = 8'h02; p[7] = 8'h06;
        boot(p);
        for (int n = 1; n <= 14; n++) begin
            // sampling here observes cycle n (before edge n)
            chk($sformatf("ls write cyc%0d", n), 32'(write),
                (n == 6 || n == 9) ? 32'h1 : 32'h0);
            if (n == 4) chk("ls ac after cyc3", 32'(memoryIn), 32'h06);
            if (n == 7) chk("ls M4 after cyc6", 32'(mem[4]), 32'h06);
            if (n == 12 || n == 14) begin
                chk($sformatf("ls halted read cyc%0d", n), 32'(read), 32'h0);
                chk($sformatf("ls halted addr cyc%0d", n), 32'(address), 32'h4);
            end
            cycles(1);
        end

        // ---------------- program table ----------------
        for (int k = 0; k < 11; k++) begin
            boot(vecs[k].img);
            cycles(40);
            chk($sformatf("v%0d ac", k), 32'(memoryIn), 32'(vecs[k].ac));
            chk($sformatf("v%0d z", k), 32'(dut.z_q), 32'(vecs[k].z));
            chk($sformatf("v%0d c", k), 32'(dut.c_q), 32'(vecs[k].c));
            chk($sformatf("v%0d halt pc", k), 32'(address), 32'(vecs[k].pc));
            chk($sformatf("v%0d halt strobes", k), 32'({read, write}), 32'h0);
            chk($sformatf("v%0d mem", k), 32'(mem[vecs[k].ma]), 32'(vecs[k].md));
        end

        // ---------------- wrap-around with all NOPs ----------------
        p = '1;
        boot(p);
        wcnt = 0;
        for (int n = 1; n <= 48; n++) begin
            if (write) wcnt++;
            cycles(1);
            if (n == 3) chk("wrap pc after 1 instr", 32'(address), 32'h1);
            if (n == 45) chk("wrap pc at 15", 32'(address), 32'hF);
        end
        chk("wrap pc back to 0", 32'(address), 32'h0);
        chk("wrap fetch read", 32'(read), 32'h1);
        chk("wrap no writes", 32'(wcnt), 32'h0);

        // ---------------- reset during STA execute ----------------
        p = '0;
        p[0] = 8'h77; p[1] = 8'h54; p[4] = 8'h00; p[7] = 8'h42;
        boot(p);
        cycles(5);
        chk("mid sta write", 32'(write), 32'h1);
        chk("mid sta addr", 32'(address), 32'h4);
        chk("mid sta data", 32'(memoryIn), 32'h42);
        #1 clr = 1'b0;
        #1;
        chk("mid rst write", 32'(write), 32'h0);
        chk("mid rst addr", 32'(address), 32'h0);
        chk("mid rst ac", 32'(memoryIn), 32'h0);
        chk("mid rst read", 32'(read), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("mid rst no store", 32'(mem[4]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
